hazard_scheduler: RTL

//  Issue/stall scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB).

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/dest_tag_pipe.sv | 37 +++
 rtl/hazard_scheduler.sv | 90 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU decode helpers: opcode constants, scheduler state encodings and
// register-usage decode reused by the per-stage controls.
package cpu_pkg;

  localparam logic [3:0] OPC_LOAD  = 4'b0000;
  localparam logic [3:0] OPC_STORE = 4'b0010;
  localparam logic [3:0] OPC_ADD   = 4'b0100;
  localparam logic [3:0] OPC_SUB   = 4'b0110;
  localparam logic [3:0] OPC_NAND  = 4'b1000;
  localparam logic [3:0] OPC_NOP   = 4'b1010;
  localparam logic [3:0] OPC_STOP  = 4'b0001;
  localparam logic [2:0] ORI_MASK  = 3'b111;   // matched against ir[2:0]
  localparam logic [1:0] BR_MASK   = 2'b01;    // matched against ir[1:0]
  localparam logic [7:0] NOP_IR    = {4'h0, OPC_NOP};
  localparam logic [1:0] ORI_REG   = 2'd1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  typedef struct packed {
    logic       vld;
    logic [1:0] rd;
  } tag_t;

  function automatic logic is_ori(input logic [7:0] ir);
    return ir[2:0] == ORI_MASK;
  endfunction

  function automatic logic has_dst(input logic [7:0] ir);
    if (ir[1:0] == BR_MASK) return 1'b0;
    return is_ori(ir) || (ir[3:0] inside {OPC_LOAD, OPC_ADD, OPC_SUB, OPC_NAND});
  endfunction

  function automatic logic [1:0] dst_reg(input logic [7:0] ir);
    return is_ori(ir) ? ORI_REG : ir[7:6];
  endfunction

  // One-hot set of registers read by the instruction.
  function automatic logic [3:0] src_mask(input logic [7:0] ir);
    logic [3:0] m;
    m = '0;
    if (is_ori(ir)) m[ORI_REG] = 1'b1;
    else if (ir[3:0] == OPC_LOAD) m[ir[5:4]] = 1'b1;
    else if (ir[3:0] inside {OPC_STORE, OPC_ADD, OPC_SUB, OPC_NAND}) begin
      m[ir[7:6]] = 1'b1;
      m[ir[5:4]] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/dest_tag_pipe.sv
// Destination-register tags of instructions in EX..WB; flags a read of any
// in-flight destination.
module dest_tag_pipe
  import cpu_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [1:0] push_rd,
  input  logic [3:0] src_mask,
  output logic       hit,
  output logic       empty
);

  tag_t [DEPTH-1:0] tags;
  logic [3:0]       busy;

  always_ff @(posedge clock) begin
    if (reset) tags <= '0;
    else begin
      tags[0] <= '{vld: push, rd: push_rd};
      for (int i = 1; i < DEPTH; i++) tags[i] <= tags[i-1];
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (tags[i].vld) busy[tags[i].rd] = 1'b1;
  end

  assign hit   = |(busy & src_mask);
  assign empty = ~|busy;

endmodule

// File: rtl/hazard_scheduler.sv
// Issue/stall scheduler for the 5-stage pipe: RAW stalls without forwarding,
// taken-branch squash, and drain-to-halt on stop.
module hazard_scheduler
  import cpu_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       id_ir,
  input  logic             id_valid,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [1:0] state, state_nxt;
  logic [1:0] drain_cnt;
  logic [3:0] srcs;
  logic       run, hazard, tags_empty, is_stop, issue, stall;

  assign run     = (state == ST_RUN);
  assign srcs    = id_valid ? src_mask(id_ir) : 4'b0;
  assign is_stop = id_valid && (id_ir[3:0] == OPC_STOP);
  assign stall   = run && !ex_branch_taken && hazard;
  assign issue   = run && !ex_branch_taken && !hazard && id_valid;

  dest_tag_pipe #(.DEPTH(DEPTH)) u_tags (
    .clock    (clock),
    .reset    (reset),
    .push     (issue && has_dst(id_ir)),
    .push_rd  (dst_reg(id_ir)),
    .src_mask (srcs),
    .hit      (hazard),
    .empty    (tags_empty)
  );

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b1;
    halted      = 1'b0;
    state_nxt   = state;
    if (reset) flush_ifid = 1'b1;
    else begin
      case (state)
        ST_RUN: begin
          if (ex_branch_taken) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            flush_ifid = 1'b1;
          end else if (hazard) begin
            // hold PC/IR1, bubble into EX
          end else if (is_stop) begin
            bubble_idex = 1'b0;
            state_nxt   = ST_DRAIN;
          end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            bubble_idex = 1'b0;
          end
        end
        ST_DRAIN: if (drain_cnt == 2'd2 && tags_empty) state_nxt = ST_HALT;
        ST_HALT:  halted = 1'b1;
        default:  state_nxt = ST_RUN;
      endcase
    end
  end

  // drain_cnt = cycles elapsed since stop issued, saturating at 2
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (run) drain_cnt <= 2'd1;
      else if (drain_cnt != 2'd2) drain_cnt <= drain_cnt + 2'd1;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
